// File: rtl/tt_rx_window_checker.sv
// Receive-side window checker for the time-triggered link: classifies each rising
// edge of rx against the armed schedule entry as on-time, early or late, and flags missing pulses.
module tt_rx_window_checker #(
  parameter int unsigned WIN   = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      GTB,
  input  logic [31:0]      schedule,
  input  logic             sched_valid,
  output logic             sched_ready,
  input  logic             rx,
  output logic             rx_ok,
  output logic             rx_early,
  output logic             rx_late,
  output logic             rx_missing,
  output logic             rx_unexpected,
  output logic [31:0]      rx_offset,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  localparam int signed WIN_S = int'(WIN);

  state_e             state_q, state_d;
  logic               rx_q;
  logic [31:0]        sched_q, sched_d;
  logic               ok_q, ok_d;
  logic               early_q, early_d;
  logic               late_q, late_d;
  logic               missing_q, missing_d;
  logic               unexp_q, unexp_d;
  logic [31:0]        offset_q, offset_d;
  logic [CNT_W-1:0]   err_q, err_d;

  logic               edge_det;
  logic               handshake;
  logic signed [31:0] diff;
  logic               inwin;
  logic               past;
  logic               err_evt;

  assign edge_det  = rx & ~rx_q;
  assign handshake = sched_valid & (state_q == IDLE);

  // Wrap-around subtraction read as signed keeps classification correct across GTB rollover and jumps.
  assign diff  = $signed(GTB - sched_q);
  assign inwin = (diff >= -WIN_S) && (diff <= WIN_S);
  assign past  = diff > WIN_S;

  always_comb begin
    state_d   = state_q;
    sched_d   = sched_q;
    ok_d      = 1'b0;
    early_d   = 1'b0;
    late_d    = 1'b0;
    missing_d = 1'b0;
    unexp_d   = 1'b0;
    offset_d  = offset_q;
    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          sched_d = schedule;
          state_d = ARMED;
        end
        if (edge_det) unexp_d = 1'b1;
      end
      ARMED: begin
        if (edge_det) begin
          offset_d = diff;
          if (inwin) begin
            ok_d    = 1'b1;
            state_d = IDLE;
          end else if (past) begin
            late_d  = 1'b1;
            state_d = IDLE;
          end else begin
            early_d = 1'b1;
          end
        end else if (past) begin
          missing_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    err_evt = early_d | late_d | missing_d | unexp_d;
    err_d   = err_q;
    if (err_evt && (err_q != '1)) err_d = err_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rx_q      <= 1'b0;
      sched_q   <= '0;
      ok_q      <= 1'b0;
      early_q   <= 1'b0;
      late_q    <= 1'b0;
      missing_q <= 1'b0;
      unexp_q   <= 1'b0;
      offset_q  <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      rx_q      <= rx;
      sched_q   <= sched_d;
      ok_q      <= ok_d;
      early_q   <= early_d;
      late_q    <= late_d;
      missing_q <= missing_d;
      unexp_q   <= unexp_d;
      offset_q  <= offset_d;
      err_q     <= err_d;
    end
  end

  assign sched_ready   = (state_q == IDLE);
  assign rx_ok         = ok_q;
  assign rx_early      = early_q;
  assign rx_late       = late_q;
  assign rx_missing    = missing_q;
  assign rx_unexpected = unexp_q;
  assign rx_offset     = offset_q;
  assign err_count     = err_q;

endmodule

// File: tb/tb_tt_rx_window_checker.sv
// Directed self-checking bench for tt_rx_window_checker (WIN=4, 4-bit error counter).
module tb_tt_rx_window_checker;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   gtb;
  logic [31:0]   schedule;
  logic          sched_valid;
  logic          sched_ready;
  logic          rx;
  logic          rx_ok, rx_early, rx_late, rx_missing, rx_unexpected;
  logic [31:0]   rx_offset;
  logic [CW-1:0] err_count;

  int checks   = 0;
  int failures = 0;
  logic [CW-1:0] exp_err = '0;

  // Pulse vector order: {ok, early, late, missing, unexpected}
  localparam logic [4:0] P_NONE = 5'b00000;
  localparam logic [4:0] P_OK   = 5'b10000;
  localparam logic [4:0] P_EARL = 5'b01000;
  localparam logic [4:0] P_LATE = 5'b00100;
  localparam logic [4:0] P_MISS = 5'b00010;
  localparam logic [4:0] P_UNEX = 5'b00001;

  logic [4:0] pulses;
  assign pulses = {rx_ok, rx_early, rx_late, rx_missing, rx_unexpected};

  tt_rx_window_checker #(.WIN(4), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .GTB          (gtb),
    .schedule     (schedule),
    .sched_valid  (sched_valid),
    .sched_ready  (sched_ready),
    .rx           (rx),
    .rx_ok        (rx_ok),
    .rx_early     (rx_early),
    .rx_late      (rx_late),
    .rx_missing   (rx_missing),
    .rx_unexpected(rx_unexpected),
    .rx_offset    (rx_offset),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_err();
    if (exp_err != '1) exp_err = exp_err + 1'b1;
  endtask

  task automatic arm(input logic [31:0] s, input logic [31:0] t);
    schedule = s; sched_valid = 1'b1; gtb = t; rx = 1'b0;
    step();
    sched_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b0; sched_valid = 1'b0; schedule = '0; gtb = '0;
    step(); step();
    rst = 1'b0;
    checks++;
    if (pulses !== P_NONE || rx_offset !== 32'd0 || err_count !== '0 || sched_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset: pulses=%b offset=%h err=%0d ready=%b, required 00000/0/0/1",
               pulses, rx_offset, err_count, sched_ready);
    end
  endtask

  task automatic test_ok_back_to_back();
    arm(32'd100, 32'd95);
    gtb = 32'd101; step();
    gtb = 32'd102; rx = 1'b1; step();
    checks++;
    if (pulses !== P_OK || rx_offset !== 32'd2 || err_count !== exp_err || sched_ready !== 1'b1) begin
      failures++;
      $display("FAIL ok: pulses=%b offset=%h err=%0d ready=%b, required %b/2/%0d/1",
               pulses, rx_offset, err_count, sched_ready, P_OK, exp_err);
    end
    // re-arm in the very cycle the status pulse is visible
    schedule = 32'd110; sched_valid = 1'b1; rx = 1'b0; gtb = 32'd103; step();
    sched_valid = 1'b0;
    checks++;
    if (sched_ready !== 1'b0 || pulses !== P_NONE) begin
      failures++;
      $display("FAIL b2b_arm: ready=%b pulses=%b, required 0/00000", sched_ready, pulses);
    end
    gtb = 32'd110; rx = 1'b1; step();
    checks++;
    if (pulses !== P_OK || rx_offset !== 32'd0) begin
      failures++;
      $display("FAIL b2b_ok: pulses=%b offset=%h, required %b/0", pulses, rx_offset, P_OK);
    end
    rx = 1'b0; step();
  endtask

  task automatic test_early();
    arm(32'd100, 32'd89);
    gtb = 32'd90; rx = 1'b1; step();
    bump_err();
    checks++;
    if (pulses !== P_EARL || rx_offset !== 32'hFFFF_FFF6 || err_count !== exp_err || sched_ready !== 1'b0) begin
      failures++;
      $display("FAIL early: pulses=%b offset=%h err=%0d ready=%b, required %b/fffffff6/%0d/0",
               pulses, rx_offset, err_count, sched_ready, P_EARL, exp_err);
    end
    gtb = 32'd91; rx = 1'b0; step();
    gtb = 32'd97; rx = 1'b1; step();
    checks++;
    if (pulses !== P_OK || rx_offset !== 32'hFFFF_FFFD || err_count !== exp_err) begin
      failures++;
      $display("FAIL early_then_ok: pulses=%b offset=%h err=%0d, required %b/fffffffd/%0d",
               pulses, rx_offset, err_count, P_OK, exp_err);
    end
    rx = 1'b0; step();
  endtask

  task automatic test_missing_late();
    int bad;
    arm(32'd100, 32'd100);
    bad = 0;
    for (int t = 101; t <= 104; t++) begin
      gtb = 32'(t); step();
      if (pulses !== P_NONE) bad++;
    end
    gtb = 32'd105; step();
    bump_err();
    checks++;
    if (bad != 0 || pulses !== P_MISS || rx_offset !== 32'hFFFF_FFFD || err_count !== exp_err || sched_ready !== 1'b1) begin
      failures++;
      $display("FAIL missing: early_pulses=%0d pulses=%b offset=%h err=%0d ready=%b, required 0/%b/fffffffd/%0d/1",
               bad, pulses, rx_offset, err_count, sched_ready, P_MISS, exp_err);
    end
    arm(32'd100, 32'd100);
    for (int t = 101; t <= 104; t++) begin
      gtb = 32'(t); step();
    end
    gtb = 32'd105; rx = 1'b1; step();
    bump_err();
    checks++;
    if (pulses !== P_LATE || rx_offset !== 32'd5 || err_count !== exp_err) begin
      failures++;
      $display("FAIL late: pulses=%b offset=%h err=%0d, required %b/5/%0d",
               pulses, rx_offset, err_count, P_LATE, exp_err);
    end
    rx = 1'b0; step();
  endtask

  task automatic test_wrap();
    arm(32'hFFFF_FFFE, 32'hFFFF_FFF0);
    gtb = 32'hFFFF_FFFF; step();
    gtb = 32'h0000_0001; rx = 1'b1; step();
    checks++;
    if (pulses !== P_OK || rx_offset !== 32'd3) begin
      failures++;
      $display("FAIL wrap_ok: pulses=%b offset=%h, required %b/3", pulses, rx_offset, P_OK);
    end
    rx = 1'b0; step();
    arm(32'h0000_0002, 32'hFFFF_FFF0);
    gtb = 32'hFFFF_FFFC; rx = 1'b1; step();
    bump_err();
    checks++;
    if (pulses !== P_EARL || rx_offset !== 32'hFFFF_FFFA || err_count !== exp_err) begin
      failures++;
      $display("FAIL wrap_early: pulses=%b offset=%h err=%0d, required %b/fffffffa/%0d",
               pulses, rx_offset, err_count, P_EARL, exp_err);
    end
    gtb = 32'hFFFF_FFFD; rx = 1'b0; step();
    gtb = 32'h0000_0002; rx = 1'b1; step();
    rx = 1'b0; step();
  endtask

  task automatic test_hold_high();
    int oks, others;
    arm(32'd300, 32'd290);
    oks = 0; others = 0;
    rx = 1'b1;
    for (int t = 299; t <= 303; t++) begin
      gtb = 32'(t); step();
      if (rx_ok === 1'b1) oks++;
      if ((pulses & ~P_OK) !== P_NONE) others++;
    end
    rx = 1'b0; gtb = 32'd304; step();
    checks++;
    if (oks != 1 || others != 0 || err_count !== exp_err) begin
      failures++;
      $display("FAIL hold_high: ok_pulses=%0d other_pulses=%0d err=%0d, required 1/0/%0d",
               oks, others, err_count, exp_err);
    end
  endtask

  task automatic test_unexpected();
    gtb = 32'd400; rx = 1'b1; step();
    bump_err();
    checks++;
    if (pulses !== P_UNEX || err_count !== exp_err || sched_ready !== 1'b1) begin
      failures++;
      $display("FAIL unexpected: pulses=%b err=%0d ready=%b, required %b/%0d/1",
               pulses, err_count, sched_ready, P_UNEX, exp_err);
    end
    rx = 1'b0; step();
    // handshake and edge in the same IDLE cycle
    schedule = 32'd500; sched_valid = 1'b1; rx = 1'b1; gtb = 32'd410; step();
    sched_valid = 1'b0;
    bump_err();
    checks++;
    if (pulses !== P_UNEX || sched_ready !== 1'b0 || err_count !== exp_err) begin
      failures++;
      $display("FAIL unexp_handshake: pulses=%b ready=%b err=%0d, required %b/0/%0d",
               pulses, sched_ready, err_count, P_UNEX, exp_err);
    end
    rx = 1'b0; gtb = 32'd499; step();
    gtb = 32'd500; rx = 1'b1; step();
    checks++;
    if (pulses !== P_OK || rx_offset !== 32'd0) begin
      failures++;
      $display("FAIL unexp_handshake_ok: pulses=%b offset=%h, required %b/0", pulses, rx_offset, P_OK);
    end
    rx = 1'b0; step();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) begin
      rx = 1'b1; step(); bump_err();
      rx = 1'b0; step();
    end
    checks++;
    if (err_count !== 4'hF || exp_err !== 4'hF) begin
      failures++;
      $display("FAIL saturate: err=%0d, required 15", err_count);
    end
  endtask

  task automatic test_reset_mid();
    int miss;
    arm(32'd200, 32'd190);
    for (int t = 191; t <= 197; t++) begin
      gtb = 32'(t); step();
    end
    gtb = 32'd198; rst = 1'b1; step();
    rst = 1'b0;
    exp_err = '0;
    checks++;
    if (pulses !== P_NONE || rx_offset !== 32'd0 || err_count !== '0 || sched_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid: pulses=%b offset=%h err=%0d ready=%b, required 00000/0/0/1",
               pulses, rx_offset, err_count, sched_ready);
    end
    miss = 0;
    for (int t = 199; t <= 210; t++) begin
      gtb = 32'(t); step();
      if (pulses !== P_NONE) miss++;
    end
    checks++;
    if (miss != 0 || err_count !== '0) begin
      failures++;
      $display("FAIL reset_mid_nomissing: stray_pulses=%0d err=%0d, required 0/0", miss, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_ok_back_to_back();
    test_early();
    test_missing_late();
    test_wrap();
    test_hold_high();
    test_unexpected();
    test_saturate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/tt_rx_window_checker.md
# tt_rx_window_checker

Receive-side checker for the time-triggered link. It accepts one expected arrival time from the schedule table at a time and watches the incoming `rx` line against the global time base (GTB). Each rising edge of `rx` is classified as on-time, early or late, and an expected pulse that never arrives is flagged as missing. The block sits at the receiving node, opposite the node that fires a one-cycle `tx` pulse when GTB equals its schedule entry.

## Interface
- `WIN`, default 4: acceptance half-window in GTB ticks; the window is inclusive on both sides.
- `CNT_W`, default 16: width of the saturating error counter.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `GTB` in 32: global time base; free-running and modulo 2^32.
- `schedule` in 32: expected arrival time; sampled on handshake.
- `sched_valid` in 1: `schedule` is valid.
- `sched_ready` out 1: block can accept a new schedule entry; high only in IDLE.
- `rx` in 1: incoming line from the transmitting node.
- `rx_ok` out 1: one-cycle pulse; edge arrived inside the window.
- `rx_early` out 1: one-cycle pulse; edge arrived before the window.
- `rx_late` out 1: one-cycle pulse; edge arrived on the first cycle past the window.
- `rx_missing` out 1: one-cycle pulse; window closed with no edge.
- `rx_unexpected` out 1: one-cycle pulse; edge arrived while IDLE.
- `rx_offset` out 32: signed value GTB − schedule captured at the classifying edge; holds its value until the next capture.
- `err_count` out CNT_W: saturating count of early, late, missing and unexpected events.

## Operation
- `rx_q` is the registered copy of `rx`. Edge `e` = `rx & ~rx_q`. A level held high produces a single edge.
- `sched_q` latches `schedule` when `sched_valid & sched_ready`.
- Difference `d` = GTB − `sched_q`, computed in 32-bit wrap-around arithmetic and read as two's-complement signed.
  - `inwin` = (−WIN ≤ d ≤ WIN).
  - `past` = (d > WIN).
- **IDLE**
  - `sched_ready`=1.
  - On handshake, move to ARMED.
  - `e` raises `rx_unexpected`.
  - A handshake and an edge in the same cycle give `rx_unexpected` plus the move to ARMED.
- **ARMED**
  - `e & inwin`: raise `rx_ok`, capture `rx_offset`=d, go to IDLE.
  - `e & past`: raise `rx_late`, capture `rx_offset`, go to IDLE.
  - `e & ~inwin & ~past` (early): raise `rx_early`, capture `rx_offset`, stay ARMED.
  - `~e & past`: raise `rx_missing`, go to IDLE; `rx_offset` is unchanged.
  - ARMED also covers GTB jumps, because the classification depends only on `d`, not on a GTB equality compare.
- `err_count` increments by 1 on each early, late, missing or unexpected event and saturates at 2^CNT_W−1. `rx_ok` does not count.
- At most one status pulse is asserted per cycle.
- Reset values: state IDLE, `rx_q`=0, `sched_q`=0, all pulses 0, `rx_offset`=0, `err_count`=0. `sched_ready` is 1 in the first cycle after reset.
- Reset in the middle of an operation discards the armed schedule. No `rx_missing` is reported for it.

## Timing
- The edge is sampled at cycle N, when `rx`=1 and `rx_q`=0. The classification is computed from GTB at N. Status pulse and `rx_offset` are registered and visible in cycle N+1 for exactly one cycle.
- Handshake at cycle N: `sched_ready` drops in cycle N+1, and ARMED starts evaluating at N+1.
- Missing detection: the first cycle with `past` raises `rx_missing` one cycle later. With GTB incrementing by 1, this is the cycle after GTB = schedule+WIN+1.
- After classification, `sched_ready` is high again in the cycle the status pulse is visible. A new handshake can then complete immediately.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIN=4, schedule=100, edge at GTB=102 -> `rx_ok` one cycle later, `rx_offset`=+2, `err_count`=0, `sched_ready` high again.
- Schedule=100, edge at GTB=90, then edge at GTB=97 -> `rx_early` with offset −10, state stays ARMED, then `rx_ok` with offset −3, `err_count`=1.
- Schedule=100, no edge, GTB counts up -> `rx_missing` one cycle after GTB=105, `err_count`=1. Single edge at GTB=105 instead -> `rx_late`, offset +5.
- Wrap: schedule=0xFFFFFFFE, edge at GTB=0x00000001 -> `rx_ok`, offset +3. Schedule=0x00000002, edge at GTB=0xFFFFFFFC -> `rx_early`, offset −6.
- `rx` held high for 5 cycles during the window -> exactly one `rx_ok`. Edge while IDLE -> `rx_unexpected`. Force `err_count` to 2^CNT_W−1, then one more error -> value stays at 2^CNT_W−1.
- Arm schedule=200, assert `rst` at GTB=198 -> all outputs at reset values, `sched_ready`=1, no `rx_missing` after GTB passes 205.
